// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM between instruction fetch (IF) and
// memory access (MA). Each 1/2/4-byte request becomes a series of byte cycles.
// If both ports request in the same cycle, MA is served first.
// Optional feature: define MEM_CTRL_IF_BUF_EN to add a one-entry fetch buffer.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rdy_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_done_o,
    output logic [31:0]           if_data_o,
    input  logic                  ma_req_i,
    input  logic                  ma_we_i,
    input  logic [1:0]            ma_len_i,
    input  logic [ADDR_WIDTH-1:0] ma_addr_i,
    input  logic [31:0]           ma_wdata_i,
    output logic                  ma_done_o,
    output logic [31:0]           ma_rdata_o,
    input  logic [7:0]            mem_din_i,
    output logic [7:0]            mem_dout_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic                  mem_wr_o,
    output logic                  stallreq_if_o,
    output logic                  stallreq_ma_o
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e                state_q;
    logic [2:0]            cnt_q;
    logic [2:0]            len_q;
    logic                  owner_ma_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;
    logic [31:0]           rbuf_d;
    logic                  if_done_q;
    logic                  ma_done_q;
    logic [31:0]           if_data_q;
    logic [31:0]           ma_rdata_q;
    logic [2:0]            ma_n;
    logic [1:0]            byte_sel;
    logic                  rd_last;
    logic                  buf_hit;
    logic [31:0]           buf_word;

    assign ma_n     = (ma_len_i == 2'b00) ? 3'd1 : (ma_len_i == 2'b01) ? 3'd2 : 3'd4;
    // The byte arriving now was addressed last cycle, so it belongs in slot cnt-1.
    assign byte_sel = cnt_q[1:0] - 2'd1;
    assign rd_last  = (state_q == StRd) && (cnt_q == len_q);

    // Merge the incoming RAM byte into the partial read word.
    always_comb begin
        rbuf_d = rbuf_q;
        if (cnt_q != 3'd0) begin
            rbuf_d[{byte_sel, 3'b000} +: 8] = mem_din_i;
        end
    end

`ifdef MEM_CTRL_IF_BUF_EN
    logic                  buf_valid_q;
    logic [ADDR_WIDTH-1:0] buf_addr_q;
    logic [31:0]           buf_word_q;

    assign buf_hit  = buf_valid_q && (buf_addr_q == if_addr_i);
    assign buf_word = buf_word_q;

    // Fetch buffer: fill on every IF read completion, invalidate on a granted MA write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_word_q  <= '0;
        end else if (rdy_i) begin
            if (state_q == StIdle && ma_req_i && ma_we_i) begin
                buf_valid_q <= 1'b0;
            end else if (rd_last && !owner_ma_q) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= base_q;
                buf_word_q  <= rbuf_d;
            end
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    // Arbitration, byte sequencing and registered done/data outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            owner_ma_q <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            if_done_q  <= 1'b0;
            ma_done_q  <= 1'b0;
            if_data_q  <= '0;
            ma_rdata_q <= '0;
        end else if (rdy_i) begin
            if_done_q <= 1'b0;
            ma_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q  <= '0;
                    rbuf_q <= '0;
                    if (ma_req_i) begin
                        owner_ma_q <= 1'b1;
                        base_q     <= ma_addr_i;
                        len_q      <= ma_n;
                        wdata_q    <= ma_wdata_i;
                        state_q    <= ma_we_i ? StWr : StRd;
                    end else if (if_req_i) begin
                        owner_ma_q <= 1'b0;
                        base_q     <= if_addr_i;
                        len_q      <= 3'd4;
                        if (buf_hit) begin
                            if_data_q <= buf_word;
                            if_done_q <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    rbuf_q <= rbuf_d;
                    cnt_q  <= cnt_q + 3'd1;
                    if (rd_last) begin
                        cnt_q   <= '0;
                        state_q <= StDone;
                        if (owner_ma_q) begin
                            ma_rdata_q <= rbuf_d;
                            ma_done_q  <= 1'b1;
                        end else begin
                            if_data_q <= rbuf_d;
                            if_done_q <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == len_q - 3'd1) begin
                        cnt_q     <= '0;
                        state_q   <= StDone;
                        ma_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM address/data/strobe; idle outputs are zero and writes are gated by rdy.
    always_comb begin
        mem_a_o    = '0;
        mem_dout_o = '0;
        mem_wr_o   = 1'b0;
        unique case (state_q)
            StRd: begin
                if (cnt_q < len_q) begin
                    mem_a_o = base_q + ADDR_WIDTH'(cnt_q);
                end
            end
            StWr: begin
                mem_a_o    = base_q + ADDR_WIDTH'(cnt_q);
                mem_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr_o   = rdy_i;
            end
            default: ;
        endcase
    end

    assign if_done_o     = if_done_q;
    assign ma_done_o     = ma_done_q;
    assign if_data_o     = if_data_q;
    assign ma_rdata_o    = ma_rdata_q;
    assign stallreq_if_o = if_req_i && !if_done_q;
    assign stallreq_ma_o = ma_req_i && !ma_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model (one-cycle read latency,
// gated by rdy). Build with MEM_CTRL_IF_BUF_EN to cover the fetch buffer.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req, if_done, ma_req, ma_we, ma_done, mem_wr;
    logic        stallreq_if, stallreq_ma;
    logic [31:0] if_addr, if_data, ma_addr, ma_wdata, ma_rdata, mem_a;
    logic [1:0]  ma_len;
    logic [7:0]  mem_din, mem_dout;

    int checks = 0;
    int fails  = 0;

    // Results gathered by run().
    int          lat_if, lat_ma, stall_bad, wr_in_stall, wr_pulses;
    logic [31:0] got_if, got_ma;
    logic [31:0] a_log [0:47];
    logic [7:0]  d_log [0:47];
    logic        w_log [0:47];

    logic [7:0]  ram [0:65535];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rdy_i         (rdy),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_done_o     (if_done),
        .if_data_o     (if_data),
        .ma_req_i      (ma_req),
        .ma_we_i       (ma_we),
        .ma_len_i      (ma_len),
        .ma_addr_i     (ma_addr),
        .ma_wdata_i    (ma_wdata),
        .ma_done_o     (ma_done),
        .ma_rdata_o    (ma_rdata),
        .mem_din_i     (mem_din),
        .mem_dout_o    (mem_dout),
        .mem_a_o       (mem_a),
        .mem_wr_o      (mem_wr),
        .stallreq_if_o (stallreq_if),
        .stallreq_ma_o (stallreq_ma)
    );

    // RAM model: read data one cycle after the address; frozen while rdy is low.
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram[mem_a[15:0]];
            if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        end
    end

    // Issue requests at a negedge (cycle 0) and log outputs each following cycle.
    task automatic run(input logic do_if, input logic [31:0] ia,
                       input logic do_ma, input logic we, input logic [1:0] len,
                       input logic [31:0] maddr, input logic [31:0] wd,
                       input int stall_at, input int stall_len);
        lat_if = -1; lat_ma = -1; stall_bad = 0; wr_in_stall = 0; wr_pulses = 0;
        for (int i = 0; i < 48; i++) begin
            a_log[i] = '0; d_log[i] = '0; w_log[i] = 1'b0;
        end
        if_req = do_if; if_addr = ia;
        ma_req = do_ma; ma_we = we; ma_len = len; ma_addr = maddr; ma_wdata = wd;
        for (int c = 1; c < 48; c++) begin
            @(negedge clk);
            a_log[c] = mem_a; d_log[c] = mem_dout; w_log[c] = mem_wr;
            if (mem_wr) wr_pulses++;
            if (!rdy && mem_wr) wr_in_stall++;
            if (if_req && !if_done && !stallreq_if) stall_bad++;
            if (ma_req && !ma_done && !stallreq_ma) stall_bad++;
            if (if_done && lat_if < 0) begin lat_if = c; got_if = if_data; if_req = 1'b0; end
            if (ma_done && lat_ma < 0) begin lat_ma = c; got_ma = ma_rdata; ma_req = 1'b0; end
            if (c == stall_at) rdy = 1'b0;
            if (c == stall_at + stall_len) rdy = 1'b1;
            if ((!do_if || lat_if >= 0) && (!do_ma || lat_ma >= 0)) break;
        end
        rdy = 1'b1; if_req = 1'b0; ma_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int wr_seen;
        wr_seen = 0;
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; ma_req = 1'b0; ma_we = 1'b0;
        ma_len = 2'b00; if_addr = '0; ma_addr = '0; ma_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
        end
        checks++; if (if_done !== 1'b0) begin fails++; $display("FAIL reset_if_done got=%b exp=0", if_done); end
        checks++; if (ma_done !== 1'b0) begin fails++; $display("FAIL reset_ma_done got=%b exp=0", ma_done); end
        checks++; if (mem_a !== 32'h0) begin fails++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_dout !== 8'h0) begin fails++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
        checks++; if (if_data !== 32'h0) begin fails++; $display("FAIL reset_if_data got=%h exp=0", if_data); end
        checks++; if (ma_rdata !== 32'h0) begin fails++; $display("FAIL reset_ma_rdata got=%h exp=0", ma_rdata); end
        checks++; if (stallreq_if !== 1'b0 || stallreq_ma !== 1'b0) begin
            fails++; $display("FAIL reset_stallreq got=%b%b exp=00", stallreq_if, stallreq_ma);
        end
        checks++; if (wr_seen !== 0) begin fails++; $display("FAIL reset_mem_wr_pulses got=%0d exp=0", wr_seen); end
    endtask

    task automatic test_word_read();
        run(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 0);
        checks++; if (lat_if !== 6) begin fails++; $display("FAIL word_read_latency got=%0d exp=6", lat_if); end
        checks++; if (got_if !== 32'h0000_0513) begin fails++; $display("FAIL word_read_data got=%h exp=00000513", got_if); end
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (a_log[c] !== 32'h100 + 32'(c - 1)) begin
                fails++; $display("FAIL word_read_addr cycle=%0d got=%h exp=%h", c, a_log[c], 32'h100 + 32'(c - 1));
            end
        end
        checks++; if (a_log[5] !== 32'h0) begin fails++; $display("FAIL word_read_addr_end got=%h exp=0", a_log[5]); end
        checks++; if (stall_bad !== 0) begin fails++; $display("FAIL word_read_stallreq got=%0d bad cycles exp=0", stall_bad); end
    endtask

    task automatic test_half_write();
        run(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h1002, 32'hAABB_CCDD, 0, 0);
        checks++; if (lat_ma !== 3) begin fails++; $display("FAIL half_write_latency got=%0d exp=3", lat_ma); end
        checks++; if (wr_pulses !== 2) begin fails++; $display("FAIL half_write_pulses got=%0d exp=2", wr_pulses); end
        checks++; if (w_log[1] !== 1'b1 || a_log[1] !== 32'h1002 || d_log[1] !== 8'hDD) begin
            fails++; $display("FAIL half_write_beat0 got=%b/%h/%h exp=1/00001002/dd", w_log[1], a_log[1], d_log[1]);
        end
        checks++; if (w_log[2] !== 1'b1 || a_log[2] !== 32'h1003 || d_log[2] !== 8'hCC) begin
            fails++; $display("FAIL half_write_beat1 got=%b/%h/%h exp=1/00001003/cc", w_log[2], a_log[2], d_log[2]);
        end
        checks++; if (ram[16'h1002] !== 8'hDD || ram[16'h1003] !== 8'hCC || ram[16'h1004] !== 8'h00) begin
            fails++; $display("FAIL half_write_ram got=%h %h %h exp=dd cc 00", ram[16'h1002], ram[16'h1003], ram[16'h1004]);
        end
        checks++; if (stall_bad !== 0) begin fails++; $display("FAIL half_write_stallreq got=%0d bad cycles exp=0", stall_bad); end
    endtask

    task automatic test_simultaneous();
        run(1'b1, 32'h200, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 0, 0);
        checks++; if (a_log[1] !== 32'h20) begin fails++; $display("FAIL simul_first_addr got=%h exp=00000020", a_log[1]); end
        checks++; if (lat_ma !== 3) begin fails++; $display("FAIL simul_ma_latency got=%0d exp=3", lat_ma); end
        checks++; if (got_ma !== 32'h0000_0080) begin fails++; $display("FAIL simul_ma_rdata got=%h exp=00000080", got_ma); end
        checks++; if (lat_if !== 10) begin fails++; $display("FAIL simul_if_latency got=%0d exp=10", lat_if); end
        checks++; if (got_if !== 32'h4433_2211) begin fails++; $display("FAIL simul_if_data got=%h exp=44332211", got_if); end
        checks++; if (stall_bad !== 0) begin fails++; $display("FAIL simul_stallreq got=%0d bad cycles exp=0", stall_bad); end
    endtask

    task automatic test_rdy_stall();
        run(1'b1, 32'h300, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2, 3);
        checks++; if (lat_if !== 9) begin fails++; $display("FAIL stall_read_latency got=%0d exp=9", lat_if); end
        checks++; if (got_if !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stall_read_data got=%h exp=deadbeef", got_if); end
        for (int c = 2; c <= 5; c++) begin
            checks++;
            if (a_log[c] !== 32'h301) begin fails++; $display("FAIL stall_read_addr cycle=%0d got=%h exp=00000301", c, a_log[c]); end
        end
        run(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h400, 32'h0102_0304, 1, 2);
        checks++; if (lat_ma !== 7) begin fails++; $display("FAIL stall_write_latency got=%0d exp=7", lat_ma); end
        checks++; if (wr_in_stall !== 0) begin fails++; $display("FAIL stall_write_gated got=%0d exp=0", wr_in_stall); end
        checks++; if (wr_pulses !== 4) begin fails++; $display("FAIL stall_write_pulses got=%0d exp=4", wr_pulses); end
        checks++; if ({ram[16'h403], ram[16'h402], ram[16'h401], ram[16'h400]} !== 32'h0102_0304) begin
            fails++; $display("FAIL stall_write_ram got=%h%h%h%h exp=01020304", ram[16'h403], ram[16'h402], ram[16'h401], ram[16'h400]);
        end
    endtask

    task automatic test_ma_read();
        run(1'b0, 32'h0, 1'b1, 1'b0, 2'b11, 32'h300, 32'h0, 0, 0);
        checks++; if (lat_ma !== 6) begin fails++; $display("FAIL ma_word_latency got=%0d exp=6", lat_ma); end
        checks++; if (got_ma !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ma_word_data got=%h exp=deadbeef", got_ma); end
        run(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, 0, 0);
        checks++; if (lat_ma !== 4) begin fails++; $display("FAIL ma_wrap_latency got=%0d exp=4", lat_ma); end
        checks++; if (a_log[1] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL ma_wrap_addr0 got=%h exp=ffffffff", a_log[1]); end
        checks++; if (got_ma !== 32'h0000_A55A) begin fails++; $display("FAIL ma_wrap_data got=%h exp=0000a55a", got_ma); end
    endtask

    task automatic test_reset_abort();
        int bad;
        bad = 0;
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (if_done || mem_a !== 32'h0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL abort_quiet got=%0d bad cycles exp=0", bad); end
        checks++; if (if_data !== 32'h0) begin fails++; $display("FAIL abort_if_data got=%h exp=0", if_data); end
        checks++; if (ma_rdata !== 32'h0) begin fails++; $display("FAIL abort_ma_rdata got=%h exp=0", ma_rdata); end
    endtask

    task automatic test_fetch_buffer();
        int exp_hit;
`ifdef MEM_CTRL_IF_BUF_EN
        exp_hit = 1;
`else
        exp_hit = 6;
`endif
        run(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 0);
        checks++; if (lat_if !== 6) begin fails++; $display("FAIL buf_first_latency got=%0d exp=6", lat_if); end
        run(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 0);
        checks++; if (lat_if !== exp_hit) begin fails++; $display("FAIL buf_refetch_latency got=%0d exp=%0d", lat_if, exp_hit); end
        checks++; if (got_if !== 32'h0000_0513) begin fails++; $display("FAIL buf_refetch_data got=%h exp=00000513", got_if); end
        checks++; if (a_log[1] !== (exp_hit == 1 ? 32'h0 : 32'h100)) begin
            fails++; $display("FAIL buf_refetch_addr got=%h exp=%h", a_log[1], (exp_hit == 1 ? 32'h0 : 32'h100));
        end
        run(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h500, 32'h0000_0077, 0, 0);
        checks++; if (lat_ma !== 2) begin fails++; $display("FAIL buf_write_latency got=%0d exp=2", lat_ma); end
        run(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 0);
        checks++; if (lat_if !== 6) begin fails++; $display("FAIL buf_after_write_latency got=%0d exp=6", lat_if); end
        checks++; if (got_if !== 32'h0000_0513) begin fails++; $display("FAIL buf_after_write_data got=%h exp=00000513", got_if); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05;
        ram[16'h0020] <= 8'h80;
        ram[16'h0200] <= 8'h11; ram[16'h0201] <= 8'h22; ram[16'h0202] <= 8'h33; ram[16'h0203] <= 8'h44;
        ram[16'h0300] <= 8'hEF; ram[16'h0301] <= 8'hBE; ram[16'h0302] <= 8'hAD; ram[16'h0303] <= 8'hDE;
        ram[16'hFFFF] <= 8'h5A; ram[16'h0000] <= 8'hA5;
        test_reset();
        test_word_read();
        test_half_write();
        test_simultaneous();
        test_rdy_stall();
        test_ma_read();
        test_reset_abort();
        test_fetch_buffer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller that shares the 8-bit external RAM between instruction fetch (IF) and memory access (MA). It serialises 1/2/4-byte requests into byte-wide RAM cycles, gives MA priority over IF, and raises per-requester stall requests to the pipeline stall controller. The 5-bit stall vector that drives the pipeline registers, including the MA→WB register, is built from these requests.

## Interface
- ADDR_WIDTH, 32, width of every address port; address arithmetic wraps modulo 2^ADDR_WIDTH.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_WIDTH  fetch address; always a 4-byte read.
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  out  32  fetched word, little-endian.
- ma_req  in  1  MA request; held high until ma_done.
- ma_we  in  1  1 = write, 0 = read.
- ma_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- ma_addr  in  ADDR_WIDTH  byte address.
- ma_wdata  in  32  write data; byte k is bits [8k+7:8k].
- ma_done  out  1  one-cycle pulse; ma_rdata valid in the same cycle.
- ma_rdata  out  32  read data, zero-extended. Sign extension is done in MA.
- mem_din  in  8  RAM read byte; arrives one cycle after the address.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  RAM write strobe.
- stallreq_if  out  1  if_req && !if_done.
- stallreq_ma  out  1  ma_req && !ma_done.

## Operation
- States: IDLE, RD, WR, DONE. There is a byte counter cnt (0..4), a latched owner (IF/MA), and latched base address, length N, and wdata.
- **IDLE:**
  - If ma_req, grant MA: latch fields, cnt=0, go to WR if ma_we, else RD.
  - Else if if_req, grant IF: N=4, go to RD.
  - MA always wins on simultaneous requests.
- **RD:**
  - While cnt<N: mem_a = base+cnt.
  - While cnt≥1: capture mem_din into byte cnt-1 of the result register.
  - cnt increments each cycle. At cnt==N, capture the last byte and go to DONE.
- **WR:**
  - mem_a = base+cnt, mem_dout = wdata byte cnt, mem_wr=1.
  - At cnt==N-1, go to DONE.
- **DONE:**
  - Assert the owner's done for exactly one cycle, with the result on its data port.
  - Return to IDLE. Requests are not sampled in DONE.
- In IDLE and DONE, mem_a=0, mem_dout=0, mem_wr=0.
- Unused upper bytes of ma_rdata are 0.
- Once granted, a transfer always completes, even if req drops mid-transfer. The done pulse is still issued.
- A requester must drive req low in the cycle after its done. Otherwise it is re-granted.
- Other-port requests arriving mid-transfer wait in IDLE arbitration.

## Timing
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0.
  - if_done, ma_done, mem_wr = 0.
  - mem_a, mem_dout = 0.
  - if_data, ma_rdata = 0.
  - Buffer invalid.
  - Reset mid-transfer aborts it with no done pulse. Writes already issued are not undone.
- Read latency, request-seen cycle to done: N+2 cycles. A word read takes 6 cycles.
- Write latency, request-seen cycle to done: N+1 cycles.
- rdy=0:
  - All registers hold.
  - mem_wr is forced to 0.
  - done outputs hold their value. The external RAM is gated by the same rdy.
- stallreq_* are combinational from req and registered done, with no extra latency.

## Configuration
- MEM_CTRL_IF_BUF_EN defined:
  - A one-entry fetch buffer (address + word + valid) is filled on every IF completion.
  - In IDLE, if there is no ma_req, if_req is set, valid=1 and if_addr equals the buffer address, go directly to DONE. No RAM cycles are issued, and if_done comes the next cycle (latency 1).
  - Any granted MA write clears valid.
- MEM_CTRL_IF_BUF_EN undefined: no buffer, and every fetch takes 6 cycles.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 → all outputs 0, state IDLE, mem_wr never pulses.
- Word read: IF fetch at 0x100, RAM holds 0x13,0x05,0x00,0x00 → mem_a sequence is 0x100..0x103, if_data=0x00000513, and if_done comes 6 cycles after the request.
- Half-word write: ma_we=1, ma_len=01, addr=0x1002, wdata=0xAABBCCDD → mem_wr=1 for 2 cycles with (0x1002, 0xDD) then (0x1003, 0xCC), and ma_done 3 cycles after the request.
- Simultaneous if_req and ma_req (byte read at 0x20 = 0x80) → MA is served first (ma_rdata=0x00000080), then IF is served. stallreq_if stays high throughout.
- rdy=0 for 3 cycles mid-read → cnt and mem_a are frozen and mem_wr=0. The result matches a run with no stall.
- Buffer enabled: two fetches of 0x100 → the second gives if_done after 1 cycle with no mem_a activity. After an intervening MA write, a refetch takes 6 cycles.
